// File: rtl/foo_operand_packer.sv
// Packs pairs of 32-bit operands into the 64-bit {a, b} word for the foo adder pipeline.
// Optional FOO_PACK_FLUSH_EN adds a flush input that pads a lone held word with zeros.
module foo_operand_packer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
`ifdef FOO_PACK_FLUSH_EN
    input  logic             flush,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_s,
    output logic [CNT_W-1:0] pair_count
);

    // State bits are {half_valid, out_valid}.
    typedef enum logic [1:0] {
        StEmpty   = 2'b00,
        StOut     = 2'b01,
        StHalf    = 2'b10,
        StHalfOut = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic               half_valid;
    logic               out_load_ok;
    logic               in_fire;
    logic               out_fire;
    logic               pad_fire;
    logic               load;
    logic [31:0]        half_q;
    logic [63:0]        out_s_q;
    logic [CNT_W-1:0]   cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (in_fire) state_d = StHalf;
            end
            StHalf: begin
                if (in_fire || pad_fire) state_d = StOut;
            end
            StOut: begin
                unique case ({in_fire, out_fire})
                    2'b10:   state_d = StHalfOut;
                    2'b11:   state_d = StHalf;
                    2'b01:   state_d = StEmpty;
                    default: state_d = StOut;
                endcase
            end
            StHalfOut: begin
                // A load here always frees the half slot and refills the output.
                if (in_fire || pad_fire) state_d = StOut;
                else if (out_fire)       state_d = StHalf;
            end
            default: state_d = StEmpty;
        endcase
    end

    always_comb begin
        half_valid  = state_q[1];
        out_valid   = state_q[0];
        out_load_ok = !out_valid || out_ready;
        in_ready    = !half_valid || out_load_ok;
        in_fire     = in_valid && in_ready;
        out_fire    = out_valid && out_ready;
`ifdef FOO_PACK_FLUSH_EN
        // An input beat in the same cycle wins; the flush request is dropped.
        pad_fire    = flush && !in_fire && half_valid && out_load_ok;
`else
        pad_fire    = 1'b0;
`endif
        load        = (in_fire && half_valid) || pad_fire;
        out_s       = out_s_q;
        pair_count  = cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_q  <= 32'h0;
            out_s_q <= 64'h0;
            cnt_q   <= '0;
        end else begin
            if (in_fire && !half_valid) begin
                half_q <= in_data;
            end
            if (load) begin
                out_s_q <= {half_q, (in_fire ? in_data : 32'h0)};
            end
            if (out_fire) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule
